// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, RV32 major opcodes and the fetch entry payload.
package core_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    // Major opcodes, inst[6:0]
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [ILEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry FIFO of fetch entries with flush; head entry is read straight from storage flops.
module fetch_fifo
    import core_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  fetch_entry_t                 wdata,
    input  logic                         pop,
    input  logic                         flush,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output fetch_entry_t                 rdata
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return PTR_W'((32'(p) + 32'd1) % DEPTH);
    endfunction

    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign rdata = mem_q[rd_ptr_q];

    // Pointer and storage update; flush wins over a simultaneous push or pop.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // State registers; storage is cleared so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited word requests, in-order response buffering, redirect with squash.
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [6:0]      inst_opcode
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             running_q, running_d;

    logic             req_fire, resp_fire, resp_keep;
    logic [31:0]      credit_used;
    logic [CNT_W-1:0] outstanding_next;

    logic             ibuf_pop, ibuf_full, ibuf_empty;
    logic [CNT_W-1:0] ibuf_count;
    fetch_entry_t     ibuf_wdata, ibuf_rdata;

    logic             pcq_full, pcq_empty;
    logic [CNT_W-1:0] pcq_count;
    fetch_entry_t     pcq_wdata, pcq_rdata;

    // Status bits and fields that the slot accounting never needs.
    logic unused_fifo_bits;
    assign unused_fifo_bits = ^{ibuf_full, pcq_full, pcq_rdata.inst};

    // Request credit: every in-flight request owns a buffer slot, and a slot freed by
    // this cycle's pop may be re-reserved at once so k=1 sustains one fetch per cycle.
    always_comb begin
        credit_used    = 32'(pcq_count) + 32'(ibuf_count) - 32'(ibuf_pop);
        imem_req_valid = running_q && !redirect_valid && (credit_used < DEPTH);
        req_fire       = imem_req_valid && imem_req_ready;
        resp_fire      = imem_resp_valid && !pcq_empty;
        resp_keep      = resp_fire && (drop_q == '0);
    end

    assign ibuf_pop   = !ibuf_empty && inst_ready;
    assign pcq_wdata  = '{inst: '0, pc: pc_q};
    assign ibuf_wdata = '{inst: imem_resp_data, pc: pcq_rdata.pc};

    assign imem_req_addr = pc_q;
    assign inst_valid    = !ibuf_empty;
    assign inst          = ibuf_rdata.inst;
    assign inst_pc       = ibuf_rdata.pc;
    assign inst_opcode   = ibuf_rdata.inst[6:0];

    // PC of every accepted request, popped by its response whether kept or squashed.
    fetch_fifo #(.DEPTH(DEPTH)) u_pc_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (req_fire),
        .wdata (pcq_wdata),
        .pop   (resp_fire),
        .flush (1'b0),
        .full  (pcq_full),
        .empty (pcq_empty),
        .count (pcq_count),
        .rdata (pcq_rdata)
    );

    // Instructions waiting for decode; a redirect empties it.
    fetch_fifo #(.DEPTH(DEPTH)) u_inst_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (resp_keep),
        .wdata (ibuf_wdata),
        .pop   (ibuf_pop),
        .flush (redirect_valid),
        .full  (ibuf_full),
        .empty (ibuf_empty),
        .count (ibuf_count),
        .rdata (ibuf_rdata)
    );

    // Next PC, squash counter and run enable.
    always_comb begin
        pc_d             = pc_q;
        drop_d           = drop_q;
        running_d        = 1'b1;
        outstanding_next = CNT_W'(32'(pcq_count) + 32'(req_fire) - 32'(resp_fire));
        if (redirect_valid) begin
            pc_d   = {redirect_pc[XLEN-1:2], 2'b00};
            drop_d = outstanding_next;
        end else begin
            if (req_fire) begin
                pc_d = pc_q + XLEN'(4);
            end
            if (resp_fire && (drop_q != '0)) begin
                drop_d = drop_q - CNT_W'(1);
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q      <= RESET_PC;
            drop_q    <= '0;
            running_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            drop_q    <= drop_d;
            running_q <= running_d;
        end
    end

endmodule
